// File: rtl/pipe_issue.sv
// Instruction issue unit: FIFO-buffered instructions issued one per cycle, with a
// destination-register scoreboard that inserts bubbles on read-after-write hazards.
module pipe_issue #(
  parameter int DEPTH   = 8,
  parameter int HAZ_WIN = 3,
  parameter int RW      = 10,
  parameter int AW      = 10
) (
  input  logic                       clk1,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [RW-1:0]              in_rs1,
  input  logic [RW-1:0]              in_rs2,
  input  logic [RW-1:0]              in_rd,
  input  logic [3:0]                 in_func,
  input  logic [AW-1:0]              in_addr,
  input  logic                       run,
  output logic [RW-1:0]              rs1,
  output logic [RW-1:0]              rs2,
  output logic [RW-1:0]              rd,
  output logic [3:0]                 func,
  output logic [AW-1:0]              addr,
  output logic                       issue_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic [15:0]                stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 3 * RW + 4 + AW;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // Entry layout, MSB first: {rs1, rs2, rd, func, addr}
  logic [EW-1:0]   mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [HAZ_WIN-1:0] sb_v_r;
  logic [RW-1:0]   sb_rd_r [HAZ_WIN];

  logic [RW-1:0]   rs1_r, rs2_r, rd_r;
  logic [3:0]      func_r;
  logic [AW-1:0]   addr_r;
  logic            issue_valid_r;
  logic [15:0]     stall_cnt_r;

  logic [EW-1:0]   head_s;
  logic [RW-1:0]   head_rs1_s, head_rs2_s, head_rd_s;
  logic            push_s, eligible_s, hazard_s, pop_s, bubble_s;

  assign head_s     = mem_r[rd_ptr_r];
  assign head_rs1_s = head_s[EW-1 -: RW];
  assign head_rs2_s = head_s[EW-RW-1 -: RW];
  assign head_rd_s  = head_s[AW+4 +: RW];

  assign in_ready   = (count_r < FULL_C);
  assign push_s     = in_valid & in_ready;
  assign eligible_s = run & (count_r != {CW{1'b0}});
  assign pop_s      = eligible_s & ~hazard_s;
  assign bubble_s   = eligible_s & hazard_s;

  assign count       = count_r;
  assign empty       = (count_r == {CW{1'b0}});
  assign rs1         = rs1_r;
  assign rs2         = rs2_r;
  assign rd          = rd_r;
  assign func        = func_r;
  assign addr        = addr_r;
  assign issue_valid = issue_valid_r;
  assign stall_cnt   = stall_cnt_r;

  // Hazard: any live scoreboard slot whose rd is a source of the head.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      if (sb_v_r[i] && ((sb_rd_r[i] == head_rs1_s) || (sb_rd_r[i] == head_rs2_s))) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {EW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {in_rs1, in_rs2, in_rd, in_func, in_addr};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Scoreboard shifts every cycle, so hazards drain even while idle.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      sb_v_r <= {HAZ_WIN{1'b0}};
      for (int i = 0; i < HAZ_WIN; i++) sb_rd_r[i] <= {RW{1'b0}};
    end else begin
      for (int i = HAZ_WIN - 1; i > 0; i--) begin
        sb_v_r[i]  <= sb_v_r[i-1];
        sb_rd_r[i] <= sb_rd_r[i-1];
      end
      sb_v_r[0]  <= pop_s;
      sb_rd_r[0] <= pop_s ? head_rd_s : {RW{1'b0}};
    end
  end

  // Issued fields hold their last value; bubble counter saturates.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      rs1_r         <= {RW{1'b0}};
      rs2_r         <= {RW{1'b0}};
      rd_r          <= {RW{1'b0}};
      func_r        <= 4'h0;
      addr_r        <= {AW{1'b0}};
      issue_valid_r <= 1'b0;
      stall_cnt_r   <= 16'h0000;
    end else begin
      issue_valid_r <= pop_s;
      if (pop_s) begin
        {rs1_r, rs2_r, rd_r, func_r, addr_r} <= head_s;
      end
      if (bubble_s && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_pipe_issue.sv
// Directed and randomized bench for pipe_issue, checked against a queue-based
// model that tracks issued destinations by the edge at which they issued.
module tb_pipe_issue;

  localparam int DEPTH   = 8;
  localparam int HAZ_WIN = 3;
  localparam int RW      = 10;
  localparam int AW      = 10;
  localparam int CW      = 4;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          run = 1'b0;
  logic [RW-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [3:0]    in_func = '0;
  logic [AW-1:0] in_addr = '0;
  logic          in_ready, issue_valid, empty;
  logic [RW-1:0] rs1, rs2, rd;
  logic [3:0]    func;
  logic [AW-1:0] addr;
  logic [CW-1:0] count;
  logic [15:0]   stall_cnt;

  pipe_issue #(.DEPTH(DEPTH), .HAZ_WIN(HAZ_WIN), .RW(RW), .AW(AW)) dut (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
    .run(run), .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .issue_valid(issue_valid), .count(count), .empty(empty), .stall_cnt(stall_cnt)
  );

  always #5 clk1 = ~clk1;

  typedef struct packed {
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
    logic [3:0]    func;
    logic [AW-1:0] addr;
  } ins_t;

  ins_t          mq[$];
  int            rec_edge[$];
  logic [RW-1:0] rec_rd[$];
  int            edge_no = 0;
  ins_t          m_out = '0;
  bit            m_iv = 1'b0;
  int            m_stall = 0;
  bit            m_pushed = 1'b0;
  int            total = 0;
  int            bad = 0;
  int            issue_seen = 0;
  int            first_issue_edge = 0;
  int            last_issue_edge = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input ins_t w);
    in_rs1  = w.rs1;
    in_rs2  = w.rs2;
    in_rd   = w.rd;
    in_func = w.func;
    in_addr = w.addr;
  endtask

  function automatic ins_t mk(input int a, input int b, input int d, input int f, input int ad);
    ins_t w;
    w.rs1 = RW'(a); w.rs2 = RW'(b); w.rd = RW'(d); w.func = 4'(f); w.addr = AW'(ad);
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    rec_edge.delete();
    rec_rd.delete();
    m_out   = '0;
    m_iv    = 1'b0;
    m_stall = 0;
  endtask

  // One clock: predict from the pre-edge state, then compare after the edge.
  task automatic step();
    bit   elig, haz;
    ins_t h, w;
    w = {in_rs1, in_rs2, in_rd, in_func, in_addr};
    chk("in_ready", in_ready, mq.size() < DEPTH);
    edge_no++;
    elig = run && (mq.size() > 0);
    haz  = 1'b0;
    if (elig) begin
      h = mq[0];
      foreach (rec_edge[i])
        if ((edge_no - rec_edge[i] <= HAZ_WIN) && (rec_rd[i] == h.rs1 || rec_rd[i] == h.rs2))
          haz = 1'b1;
    end
    m_pushed = in_valid && (mq.size() < DEPTH);
    m_iv = 1'b0;
    if (elig && !haz) begin
      m_out = mq.pop_front();
      m_iv  = 1'b1;
      rec_edge.push_back(edge_no);
      rec_rd.push_back(m_out.rd);
    end else if (elig && m_stall < 65535) begin
      m_stall++;
    end
    if (m_pushed) mq.push_back(w);
    while (rec_edge.size() > 0 && (edge_no - rec_edge[0] >= HAZ_WIN)) begin
      void'(rec_edge.pop_front());
      void'(rec_rd.pop_front());
    end
    @(posedge clk1);
    #1;
    chk("issue_valid", issue_valid, m_iv);
    chk("fields", {rs1, rs2, rd, func, addr}, m_out);
    chk("count", count, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("stall_cnt", stall_cnt, m_stall);
    if (issue_valid) begin
      if (issue_seen == 0) first_issue_edge = edge_no;
      issue_seen++;
      last_issue_edge = edge_no;
    end
  endtask

  initial begin
    ins_t w;
    bit   hold;

    // Power-on reset
    #12;
    rst_n = 1'b1;
    @(posedge clk1);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    step();

    // Independent stream: one issue per cycle, no bubbles
    run = 1'b1;
    issue_seen = 0;
    for (int i = 0; i < 10; i++) begin
      set_word(mk(3 + i, 3 + i, 10 + 2 * i, i, 125 + i));
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("stream_issues", issue_seen, 10);
    chk("stream_span", last_issue_edge - first_issue_edge, 9);
    chk("stream_stall", stall_cnt, 0);
    chk("stream_last_addr", addr, 134);

    // RAW hazard: consumer issues 4 edges after producer, 3 bubbles
    issue_seen = 0;
    set_word(mk(3, 3, 10, 0, 1)); in_valid = 1'b1; step();
    set_word(mk(10, 10, 12, 1, 2)); step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("raw_issues", issue_seen, 2);
    chk("raw_gap", last_issue_edge - first_issue_edge, 4);
    chk("raw_stall", stall_cnt, 3);
    chk("raw_rd", rd, 12);

    // Run gap while the head is stalled: no extra bubbles counted
    set_word(mk(1, 1, 20, 2, 3)); in_valid = 1'b1; step();
    set_word(mk(20, 20, 22, 3, 4)); step();
    in_valid = 1'b0;
    step();
    chk("gap_bubble", stall_cnt, 4);
    run = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("gap_stall_frozen", stall_cnt, 4);
    run = 1'b1;
    step();
    chk("gap_issue_now", issue_valid, 1);
    chk("gap_issue_rd", rd, 22);
    step();

    // Full FIFO: 9th word refused, then 8 issues in order
    run = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_word(mk(i, i, 100 + i, i, 300 + i));
      step();
    end
    chk("full_ready", in_ready, 0);
    chk("full_count", count, 8);
    set_word(mk(9, 9, 109, 9, 309));
    step();
    chk("full_9th_refused", count, 8);
    in_valid = 1'b0;
    run = 1'b1;
    issue_seen = 0;
    for (int i = 0; i < 9; i++) step();
    chk("full_drain_issues", issue_seen, 8);
    chk("full_drain_empty", empty, 1);
    chk("full_last_addr", addr, 307);

    // Steady stream at full occupancy across pointer wrap
    run = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_word(mk(i, i, 600 + i, i, 400 + i));
      step();
    end
    run = 1'b1;
    issue_seen = 0;
    hold = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!hold)
        set_word(mk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(512, 1023),
                    $urandom_range(0, 15), $urandom_range(0, 1023)));
      step();
      hold = !m_pushed;
      chk("steady_count_range", (count >= 7) && (count <= 8), 1);
    end
    chk("steady_throughput", issue_seen >= 20, 1);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // Randomized traffic with frequent hazards
    hold = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!hold) begin
        w = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 15), $urandom_range(0, 1023));
        set_word(w);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      run = ($urandom_range(0, 4) != 0);
      step();
      hold = in_valid && !m_pushed;
    end

    // Asynchronous reset mid-cycle with 3 entries queued
    in_valid = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 12; i++) step();
    run = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_word(mk(5, 6, 7, 8, 9 + i));
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", count, 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_ready", in_ready, 1);
    chk("arst_valid", issue_valid, 0);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_fields", {rs1, rs2, rd, func, addr}, 0);
    model_reset();
    @(posedge clk1);
    #4;
    rst_n = 1'b1;
    @(posedge clk1);
    #1;
    chk("post_rst_count", count, 0);
    run = 1'b1;
    for (int i = 0; i < 3; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_issue.md
# pipe_issue

Instruction issue unit for the two-phase arithmetic pipeline. It sits between a host or loader and the pipeline's instruction port (`rs1`, `rs2`, `rd`, `func`, `addr`). Instructions are buffered in a small FIFO and issued at most one per cycle. Read-after-write hazards are handled by a scoreboard that inserts bubbles, so the pipeline itself never needs to stall. It runs on the pipeline's stage-1 clock.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of 2, at least 2.
- `HAZ_WIN`, 3: number of cycles an issued `rd` stays busy in the scoreboard; at least 1.
- `RW`, 10: register-index width.
- `AW`, 10: memory-address width.
- `clk1` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: host presents an instruction.
- `in_ready` out 1: FIFO can accept; combinational, `count < DEPTH`.
- `in_rs1`, `in_rs2`, `in_rd` in RW each: source and destination register indices.
- `in_func` in 4: ALU function code.
- `in_addr` in AW: result memory address.
- `run` in 1: issue enable.
- `rs1`, `rs2`, `rd` out RW each: registered issued fields.
- `func` out 4: registered issued field.
- `addr` out AW: registered issued field.
- `issue_valid` out 1: registered; high for exactly the cycles in which the fields are a new instruction.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.
- `empty` out 1: `count == 0`.
- `stall_cnt` out 16: hazard bubbles inserted; saturates at 0xFFFF.

## Operation
- **Push:** occurs when `in_valid && in_ready` at the edge. The entry stored is {rs1, rs2, rd, func, addr}. Words presented while `in_ready` is low are ignored; the host must hold them.
- **Head:** the oldest FIFO entry. It is eligible for issue only when `run && !empty` before the edge, so a word pushed at edge N cannot issue before edge N+1.
- **Scoreboard:** a shift register `sb[0..HAZ_WIN-1]` of {v, rd}. Every edge it shifts `sb[i+1] <= sb[i]`. Slot `sb[0]` is loaded with {1, rd} on issue and {0, 0} otherwise.
- **Hazard:** exists when any `sb[i].v` is set and `sb[i].rd` equals `head.rs1` or `head.rs2`. Write-after-write and `rd`-only matches are not hazards.
- **Issue:** when eligible and there is no hazard, the unit pops the head, registers its fields onto the outputs and sets `issue_valid = 1`.
- **Bubble:** when eligible and a hazard exists, the head stays, `issue_valid = 0`, and `stall_cnt` increments.
- **Idle:** when `run = 0` or the FIFO is empty, `issue_valid = 0` and `stall_cnt` is unchanged. The scoreboard keeps shifting, so hazards drain while idle.
- **Output hold:** field outputs keep their last issued values whenever `issue_valid = 0`.
- **Push and pop in the same cycle:** `count` is unchanged.
- **Push when full:** impossible, because `in_ready` is low even if a pop occurs in that same cycle.
- **Pointer wrap:** read and write pointers wrap modulo DEPTH. `count` distinguishes full from empty.

## Timing
- **Reset (asynchronous, any time, including mid-burst):**
  - FIFO is emptied and all queued words are discarded.
  - Scoreboard is cleared.
  - `rs1`, `rs2`, `rd`, `func`, `addr` = 0.
  - `issue_valid` = 0, `stall_cnt` = 0, `count` = 0.
  - `empty` = 1, `in_ready` = 1.
- **Latency:** push at edge N gives `issue_valid` after edge N+1 at the earliest, when there is no hazard and `run` is high.
- **Throughput:** one instruction per cycle for independent instructions.
- **Dependent instructions:** if the producer issues at edge T, the consumer issues at edge T+HAZ_WIN+1 at the earliest. Exactly HAZ_WIN bubbles are counted when the consumer is already at the head.
- **`run` deasserted:** takes effect at the next edge. Dropping `run` while the head is stalled does not count further bubbles.

## Test plan
- **Reset values:** assert `rst_n` low mid-cycle with 3 entries queued -> all outputs at their reset values immediately, without waiting for a clock edge. After release, `count` = 0.
- **Independent stream:** push 10 instructions with rs1 = rs2 = 3..12, rd = 10, 12, ... 28, func = 0..9, addr = 125..134; hold `run` = 1 -> ten consecutive `issue_valid` cycles with fields in order and `stall_cnt` = 0. The rs1 = 10 and rs1 = 12 instructions must not stall, because their producers are more than HAZ_WIN issues earlier.
- **RAW hazard:** push {rs1 = 3, rd = 10} then {rs1 = 10, rd = 12} -> exactly 3 bubbles, the second instruction issues at producer edge + 4, and `stall_cnt` = 3.
- **Full FIFO:** with `run` = 0, push 9 words -> `in_ready` = 0 after 8 pushes and the 9th word is not accepted. Raise `run` -> 8 issues in order, then `empty` = 1.
- **Simultaneous push/pop at full:** hold a steady stream at `count` = 8 with `run` = 1 -> `count` stays between 7 and 8, with no loss or duplication across pointer wrap. Verify over at least 20 words with a scoreboard model.
- **`run` gap during a hazard:** drop `run` for 5 cycles while the head is stalled -> no further `stall_cnt` increments. The instruction issues on the first edge after `run` returns.
